// File: rtl/mem_wb_port_arbiter.sv
// Writeback port arbiter: per-source FIFOs, fixed priority with aging override,
// registered winning packet toward the memory writeback stage.
module mem_wb_port_arbiter #(
    parameter int unsigned NUM_REQ  = 3,
    parameter int unsigned PKT_W    = 128,
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       recoverFlag_i,
    input  logic                       portBusy_i,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    input  logic [NUM_REQ*PKT_W-1:0]   req_pkt_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    output logic                       wb_valid_o,
    output logic [PKT_W-1:0]           wb_pkt_o,
    output logic [$clog2(NUM_REQ)-1:0] wb_src_o,
    output logic                       starve_o
);

    localparam int unsigned SRC_W = $clog2(NUM_REQ);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned AGE_W = $clog2(MAX_WAIT + 1);

    logic [PKT_W-1:0] mem_q    [NUM_REQ][DEPTH];
    logic [PTR_W-1:0] wr_ptr_q [NUM_REQ];
    logic [PTR_W-1:0] wr_ptr_d [NUM_REQ];
    logic [PTR_W-1:0] rd_ptr_q [NUM_REQ];
    logic [PTR_W-1:0] rd_ptr_d [NUM_REQ];
    logic [CNT_W-1:0] count_q  [NUM_REQ];
    logic [CNT_W-1:0] count_d  [NUM_REQ];
    logic [AGE_W-1:0] age_q    [NUM_REQ];
    logic [AGE_W-1:0] age_d    [NUM_REQ];

    logic               wb_valid_d;
    logic [PKT_W-1:0]   wb_pkt_d;
    logic [SRC_W-1:0]   wb_src_d;
    logic               starve_d;

    logic               flush_c;
    logic [NUM_REQ-1:0] cand_c;
    logic [NUM_REQ-1:0] push_c;
    logic [NUM_REQ-1:0] pop_c;
    logic               starve_hit_c;
    logic               prio_hit_c;
    logic [SRC_W-1:0]   starve_idx_c;
    logic [SRC_W-1:0]   prio_idx_c;
    logic [SRC_W-1:0]   grant_idx_c;
    logic               grant_c;

    assign flush_c = reset | recoverFlag_i;

    // Candidate selection: lowest aged-out source first, else lowest non-empty source.
    always_comb begin
        starve_hit_c = 1'b0;
        prio_hit_c   = 1'b0;
        starve_idx_c = '0;
        prio_idx_c   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand_c[i]      = (count_q[i] != '0);
            req_ready_o[i] = (count_q[i] < CNT_W'(DEPTH)) & ~flush_c;
            push_c[i]      = req_valid_i[i] & req_ready_o[i];
            if (cand_c[i] && !prio_hit_c) begin
                prio_hit_c = 1'b1;
                prio_idx_c = SRC_W'(i);
            end
            if (cand_c[i] && (age_q[i] == AGE_W'(MAX_WAIT)) && !starve_hit_c) begin
                starve_hit_c = 1'b1;
                starve_idx_c = SRC_W'(i);
            end
        end
        grant_c     = ~portBusy_i & prio_hit_c;
        grant_idx_c = starve_hit_c ? starve_idx_c : prio_idx_c;
    end

    // Next-state for FIFO bookkeeping, ages and the registered output stage.
    always_comb begin
        wb_valid_d = 1'b0;
        starve_d   = 1'b0;
        wb_pkt_d   = wb_pkt_o;
        wb_src_d   = wb_src_o;
        for (int i = 0; i < NUM_REQ; i++) begin
            pop_c[i]    = grant_c && (grant_idx_c == SRC_W'(i));
            wr_ptr_d[i] = push_c[i] ? wr_ptr_q[i] + 1'b1 : wr_ptr_q[i];
            rd_ptr_d[i] = pop_c[i]  ? rd_ptr_q[i] + 1'b1 : rd_ptr_q[i];
            count_d[i]  = count_q[i] + CNT_W'(push_c[i]) - CNT_W'(pop_c[i]);
            if (cand_c[i] && !pop_c[i])
                age_d[i] = (age_q[i] == AGE_W'(MAX_WAIT)) ? age_q[i] : age_q[i] + 1'b1;
            else
                age_d[i] = '0;
            if (pop_c[i])
                wb_pkt_d = mem_q[i][rd_ptr_q[i]];
        end
        if (grant_c) begin
            wb_valid_d = 1'b1;
            wb_src_d   = grant_idx_c;
            starve_d   = starve_hit_c;
        end
        if (flush_c) begin
            wb_valid_d = 1'b0;
            starve_d   = 1'b0;
            wb_pkt_d   = '0;
            wb_src_d   = '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                wr_ptr_d[i] = '0;
                rd_ptr_d[i] = '0;
                count_d[i]  = '0;
                age_d[i]    = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_valid_o <= 1'b0;
            wb_pkt_o   <= '0;
            wb_src_o   <= '0;
            starve_o   <= 1'b0;
            for (int i = 0; i < NUM_REQ; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                count_q[i]  <= '0;
                age_q[i]    <= '0;
            end
        end else begin
            wb_valid_o <= wb_valid_d;
            wb_pkt_o   <= wb_pkt_d;
            wb_src_o   <= wb_src_d;
            starve_o   <= starve_d;
            for (int i = 0; i < NUM_REQ; i++) begin
                wr_ptr_q[i] <= wr_ptr_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
                count_q[i]  <= count_d[i];
                age_q[i]    <= age_d[i];
            end
        end
    end

    // Packet storage carries no reset; flushed entries are unreachable via the pointers.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (push_c[i])
                mem_q[i][wr_ptr_q[i]] <= req_pkt_i[i*PKT_W +: PKT_W];
        end
    end

endmodule

// File: doc/mem_wb_port_arbiter.md
Name: mem_wb_port_arbiter

Overview:
- Shares the single memory-pipe writeback port among NUM_REQ load-completion sources, e.g. 0 = cache-hit path, 1 = miss-return path, 2 = replay queue.
- Buffers each source in a small FIFO and picks one packet per cycle by fixed priority with anti-starvation aging.
- Drives the registered packet into the memory writeback stage, which builds the bypass and control packets from it.
- Flushes all buffered work on recovery.

Parameters:
- NUM_REQ, 3: number of requesting sources; index 0 has the highest fixed priority.
- PKT_W, 128: width of one writeback packet, carried opaquely.
- DEPTH, 2: entries per source FIFO; must be a power of 2 and at least 2.
- MAX_WAIT, 4: age at which a waiting source overrides fixed priority.

Ports:
- clk, in, 1: clock.
- reset, in, 1: synchronous, active-high reset.
- recoverFlag_i, in, 1: branch or exception recovery; flushes all state.
- portBusy_i, in, 1: the writeback port is taken by another user this cycle; no grant is made.
- req_valid_i, in, NUM_REQ: per-source packet valid.
- req_pkt_i, in, NUM_REQ*PKT_W: per-source packets; source i occupies bits [i*PKT_W +: PKT_W].
- req_ready_o, out, NUM_REQ: per-source FIFO can accept a packet.
- wb_valid_o, out, 1: registered packet valid toward writeback.
- wb_pkt_o, out, PKT_W: registered winning packet.
- wb_src_o, out, $clog2(NUM_REQ): index of the winning source.
- starve_o, out, 1: registered; the current wb packet was granted by the aging override.

Behaviour:
- Reset and recoverFlag_i are equivalent.
  - Every FIFO is emptied and every age counter cleared.
  - wb_valid_o=0, wb_pkt_o=0, wb_src_o=0, starve_o=0 after the edge.
  - Flush wins over push and pop in the same cycle; packets presented that cycle are dropped.
- req_ready_o[i] = (count[i] < DEPTH) & ~reset & ~recoverFlag_i.
  - It is a function of state only and does not consider a same-cycle pop, so a full FIFO never accepts, even while popping.
- Push: on a clock edge where req_valid_i[i] & req_ready_o[i], write the packet at the FIFO tail.
  - Source requests that fail this push condition are ignored by the arbiter; the source must hold the request until ready.
- Candidates: FIFO i is a candidate when count[i] > 0, judged on state at the start of the cycle. A packet pushed at edge t is first eligible in the cycle after edge t.
- Grant, made only when portBusy_i=0 and at least one candidate exists:
  - If any candidate has age[i] == MAX_WAIT, grant the lowest such index and set starve_o=1 after the edge.
  - Otherwise grant the lowest-index candidate and set starve_o=0 after the edge.
- On a grant edge: pop the head of the granted FIFO; wb_pkt_o is the head packet and wb_src_o is the granted index; wb_valid_o=1.
- On a no-grant edge: wb_valid_o=0, starve_o=0; wb_pkt_o and wb_src_o hold their previous values.
- Latency: a packet accepted at edge t appears on wb_valid_o at edge t+1 at best. There is no backpressure from writeback.
- Age counter for each source:
  - age[i] is 0 when FIFO i is empty or when source i is granted.
  - Otherwise it increments by 1 each cycle a candidate is not granted, including portBusy_i cycles, and saturates at MAX_WAIT.
  - Width is $clog2(MAX_WAIT+1).
- Push and pop on the same FIFO in one cycle: count is unchanged and the pointers both advance. Pointers wrap modulo DEPTH.
- Throughput: one packet per cycle whenever portBusy_i=0 and any FIFO is non-empty.
- Packet contents are not inspected, and the valid bit inside the packet is not checked; the packet valid bit is the caller's responsibility.

Test Plan:
- Single source: after reset, push pkt A=0x11 on src1 at edge 1 -> wb_valid_o=1 at edge 2 with wb_pkt_o=0x11, wb_src_o=1, starve_o=0; wb_valid_o=0 at edge 3.
- Fixed priority: push src0=0xA0, src2=0xC0 at the same edge -> src0 wins the next edge, src2 the edge after; wb_src_o sequence 0,2.
- Aging, MAX_WAIT=4: keep src0 continuously fed (1 packet per cycle) and load src2 once -> src2 age reaches 4 and src2 is granted with starve_o=1 no later than 5 cycles after eligibility; src0 then resumes.
- Full/backpressure: hold portBusy_i=1 and push 2 packets to src1 -> req_ready_o[1]=0. A third packet held valid is not accepted until portBusy_i drops and one pop completes; output order is preserved (FIFO).
- portBusy_i: assert for 3 cycles with src0 non-empty -> wb_valid_o=0 for those 3 edges and age[0] advances 1,2,3; grant on the first free cycle.
- Recovery: 2 packets buffered in src0 and 1 in src1, then recoverFlag_i=1 for one cycle together with req_valid_i[2]=1 -> next edge wb_valid_o=0, all FIFOs empty, src2 packet dropped; no further wb_valid_o until new pushes.
